base_ram_arbiter: RTL and testbench

BASE_RAM_ARBITER -- requirements
Module: base_ram_arbiter

---
 rtl/base_ram_arbiter_if.sv | 50 +++++
 rtl/base_ram_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_base_ram_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/base_ram_arbiter_if.sv
// Bundle between the fetch/data requesters, the arbiter and the external SRAM.
// The arbiter takes the slave view; requesters and SRAM model take the master view.
interface base_ram_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        if_ack;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic [31:0] d_rdata;
    logic        d_ack;

    logic [19:0] sram_addr;
    logic [31:0] sram_data_o;
    logic        sram_data_oe;
    logic [31:0] sram_data_i;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [3:0]  sram_be_n;

    logic        busy;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  d_req, d_we, d_addr, d_wdata, d_be,
        input  sram_data_i,
        output if_rdata, if_ack,
        output d_rdata, d_ack,
        output sram_addr, sram_data_o, sram_data_oe,
        output sram_ce_n, sram_oe_n, sram_we_n, sram_be_n,
        output busy
    );

    modport master (
        output if_req, if_addr, if_flush,
        output d_req, d_we, d_addr, d_wdata, d_be,
        output sram_data_i,
        input  if_rdata, if_ack,
        input  d_rdata, d_ack,
        input  sram_addr, sram_data_o, sram_data_oe,
        input  sram_ce_n, sram_oe_n, sram_we_n, sram_be_n,
        input  busy
    );
endinterface

// File: rtl/base_ram_arbiter.sv
// Shares one asynchronous SRAM between instruction fetch and data ports.
// Data has priority, bounded by a streak limit so a waiting fetch is not starved.
module base_ram_arbiter #(
    parameter int unsigned ACC_CYCLES = 2,
    parameter int unsigned STREAK_MAX = 4
) (
    input logic                clk,
    input logic                rst,
    base_ram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        IF_ACC,
        D_RD,
        D_WR
    } state_e;

    localparam logic [3:0] CNT_LOAD   = 4'(ACC_CYCLES - 1);
    localparam logic [3:0] STREAK_LIM = 4'(STREAK_MAX);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  streak_q, streak_d;
    logic        flush_q, flush_d;
    logic [19:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        if_ack_q, if_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic [3:0]  be_n_q, be_n_d;
    logic        data_oe_q, data_oe_d;
    logic        busy_q, busy_d;

    logic        data_win;
    logic        fetch_win;
    logic        last;
    logic        if_drop;

    logic        unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[31:22], bus.if_addr[1:0],
                                bus.d_addr[31:22], bus.d_addr[1:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        streak_d   = streak_q;
        flush_d    = flush_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;

        data_win  = bus.d_req &&
                    (!bus.if_req || (streak_q < STREAK_LIM));
        fetch_win = !data_win && bus.if_req && !bus.if_flush;
        last      = (cnt_q == 4'd0);
        if_drop   = flush_q || bus.if_flush;

        unique case (state_q)
            IDLE: begin
                if (!bus.if_req) begin
                    streak_d = '0;
                end
                if (data_win) begin
                    state_d = bus.d_we ? D_WR : D_RD;
                    cnt_d   = CNT_LOAD;
                    addr_d  = bus.d_addr[21:2];
                    wdata_d = bus.d_wdata;
                    be_d    = bus.d_be;
                    // streak saturates instead of wrapping
                    if (bus.if_req && (streak_q != 4'hF)) begin
                        streak_d = streak_q + 4'd1;
                    end
                end else if (fetch_win) begin
                    state_d  = IF_ACC;
                    cnt_d    = CNT_LOAD;
                    addr_d   = bus.if_addr[21:2];
                    streak_d = '0;
                    flush_d  = 1'b0;
                end
            end
            IF_ACC: begin
                flush_d = if_drop;
                if (last) begin
                    state_d = IDLE;
                    flush_d = 1'b0;
                    if (!if_drop) begin
                        if_rdata_d = bus.sram_data_i;
                        if_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            D_RD: begin
                if (last) begin
                    state_d   = IDLE;
                    d_rdata_d = bus.sram_data_i;
                    d_ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            D_WR: begin
                if (last) begin
                    state_d = IDLE;
                    d_ack_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // strobes are decoded from the next state so they line up with it
    always_comb begin
        ce_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
        be_n_d    = 4'hF;
        data_oe_d = 1'b0;
        busy_d    = (state_d != IDLE);

        unique case (1'b1)
            (state_d == IF_ACC): begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = 4'h0;
            end
            (state_d == D_RD): begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = ~be_d;
            end
            (state_d == D_WR): begin
                ce_n_d    = 1'b0;
                we_n_d    = 1'b0;
                be_n_d    = ~be_d;
                data_oe_d = 1'b1;
            end
            default: begin
                ce_n_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            streak_q   <= '0;
            flush_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            be_n_q     <= 4'hF;
            data_oe_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            streak_q   <= streak_d;
            flush_q    <= flush_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            be_n_q     <= be_n_d;
            data_oe_q  <= data_oe_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.if_rdata     = if_rdata_q;
    assign bus.if_ack       = if_ack_q;
    assign bus.d_rdata      = d_rdata_q;
    assign bus.d_ack        = d_ack_q;
    assign bus.sram_addr    = addr_q;
    assign bus.sram_data_o  = wdata_q;
    assign bus.sram_data_oe = data_oe_q;
    assign bus.sram_ce_n    = ce_n_q;
    assign bus.sram_oe_n    = oe_n_q;
    assign bus.sram_we_n    = we_n_q;
    assign bus.sram_be_n    = be_n_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_base_ram_arbiter.sv
// Bench for base_ram_arbiter: directed scenarios plus random traffic,
// every cycle compared against a transaction-level model.
module tb_base_ram_arbiter;

    localparam int ACC  = 2;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst;

    base_ram_arbiter_if bus();

    base_ram_arbiter #(
        .ACC_CYCLES(ACC),
        .STREAK_MAX(SMAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model: kind 0 none, 1 fetch, 2 data read, 3 data write
    int          m_kind;
    int          m_left;
    int          m_streak;
    bit          m_flushed;
    logic [19:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_if_rdata;
    logic [31:0] m_d_rdata;
    bit          m_if_ack;
    bit          m_d_ack;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endfunction

    task automatic model_step();
        if (!rst) begin
            m_kind = 0; m_left = 0; m_streak = 0; m_flushed = 0;
            m_addr = '0; m_wdata = '0; m_be = '0;
            m_if_rdata = '0; m_d_rdata = '0;
            m_if_ack = 0; m_d_ack = 0;
        end else begin
            m_if_ack = 0;
            m_d_ack  = 0;
            if (m_kind == 0) begin
                if (bus.d_req && (!bus.if_req || m_streak < SMAX)) begin
                    m_kind  = bus.d_we ? 3 : 2;
                    m_left  = ACC;
                    m_addr  = bus.d_addr[21:2];
                    m_wdata = bus.d_wdata;
                    m_be    = bus.d_be;
                    if (bus.if_req) m_streak = (m_streak >= 15) ? 15 : m_streak + 1;
                    else m_streak = 0;
                end else begin
                    if (!bus.if_req) m_streak = 0;
                    if (bus.if_req && !bus.if_flush) begin
                        m_kind = 1; m_left = ACC; m_flushed = 0;
                        m_addr = bus.if_addr[21:2];
                        m_streak = 0;
                    end
                end
            end else begin
                if (m_kind == 1 && bus.if_flush) m_flushed = 1;
                m_left--;
                if (m_left == 0) begin
                    if (m_kind == 1 && !m_flushed) begin
                        m_if_rdata = bus.sram_data_i;
                        m_if_ack = 1;
                    end
                    if (m_kind == 2) begin
                        m_d_rdata = bus.sram_data_i;
                        m_d_ack = 1;
                    end
                    if (m_kind == 3) m_d_ack = 1;
                    m_kind = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] be_n;
        be_n = (m_kind == 0) ? 4'hF : (m_kind == 1) ? 4'h0 : ~m_be;
        chk("if_ack", 32'(bus.if_ack), 32'(m_if_ack));
        chk("d_ack", 32'(bus.d_ack), 32'(m_d_ack));
        chk("if_rdata", bus.if_rdata, m_if_rdata);
        chk("d_rdata", bus.d_rdata, m_d_rdata);
        chk("sram_addr", 32'(bus.sram_addr), 32'(m_addr));
        chk("sram_data_o", bus.sram_data_o, m_wdata);
        chk("data_oe", 32'(bus.sram_data_oe), 32'(m_kind == 3));
        chk("ce_n", 32'(bus.sram_ce_n), 32'(m_kind == 0));
        chk("oe_n", 32'(bus.sram_oe_n), 32'(!(m_kind == 1 || m_kind == 2)));
        chk("we_n", 32'(bus.sram_we_n), 32'(m_kind != 3));
        chk("be_n", 32'(bus.sram_be_n), 32'(be_n));
        chk("busy", 32'(bus.busy), 32'(m_kind != 0));
        chk("ack_excl", 32'(bus.if_ack & bus.d_ack), 32'd0);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks[$];
        rst = 1'b0;
        bus.if_req = 0; bus.if_addr = '0; bus.if_flush = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0;
        bus.d_wdata = '0; bus.d_be = '0; bus.sram_data_i = '0;
        tick();
        tick();
        chk("rst_ce_n", 32'(bus.sram_ce_n), 32'd1);
        chk("rst_be_n", 32'(bus.sram_be_n), 32'hF);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_addr", 32'(bus.sram_addr), 32'd0);
        rst = 1'b1;
        tick();

        // single fetch
        bus.if_req = 1; bus.if_addr = 32'h8000_0010;
        bus.sram_data_i = 32'h1234_5678;
        tick();
        chk("f_addr", 32'(bus.sram_addr), 32'h0000_0004);
        chk("f_oe_c1", 32'(bus.sram_oe_n), 32'd0);
        tick();
        chk("f_oe_c2", 32'(bus.sram_oe_n), 32'd0);
        tick();
        chk("f_ack_c3", 32'(bus.if_ack), 32'd1);
        chk("f_rdata_c3", bus.if_rdata, 32'h1234_5678);
        bus.if_req = 0;
        tick();

        // simultaneous requests: data write first
        bus.sram_data_i = 32'hCAFE_F00D;
        bus.if_req = 1; bus.if_addr = 32'h8000_0040;
        bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0011;
        bus.d_addr = 32'h8000_0100; bus.d_wdata = 32'hA5A5_0101;
        tick();
        chk("w_we_n", 32'(bus.sram_we_n), 32'd0);
        chk("w_be_n", 32'(bus.sram_be_n), 32'hC);
        chk("w_addr", 32'(bus.sram_addr), 32'h40);
        bus.d_addr = 32'h8000_0FF0; bus.d_wdata = 32'h0;
        tick();
        chk("w_data", bus.sram_data_o, 32'hA5A5_0101);
        tick();
        chk("w_ack", 32'(bus.d_ack), 32'd1);
        bus.d_req = 0;
        tick();
        chk("wf_oe_n", 32'(bus.sram_oe_n), 32'd0);
        chk("wf_addr", 32'(bus.sram_addr), 32'h10);
        tick();
        tick();
        chk("wf_ack", 32'(bus.if_ack), 32'd1);
        chk("wf_rdata", bus.if_rdata, 32'hCAFE_F00D);
        bus.if_req = 0;
        tick();

        // flush on the exit edge of a fetch
        bus.if_req = 1; bus.sram_data_i = 32'hDEAD_0000;
        tick();
        tick();
        chk("fl_oe_c2", 32'(bus.sram_oe_n), 32'd0);
        bus.if_flush = 1; bus.if_req = 0;
        tick();
        bus.if_flush = 0;
        chk("fl_no_ack", 32'(bus.if_ack), 32'd0);
        chk("fl_rdata", bus.if_rdata, 32'hCAFE_F00D);
        chk("fl_idle", 32'(bus.sram_ce_n), 32'd1);
        tick();

        // streak limit with both requesters saturated
        bus.d_req = 1; bus.d_we = 0; bus.if_req = 1;
        for (int i = 0; i < 60 && acks.size() < 6; i++) begin
            tick();
            if (bus.d_ack) acks.push_back(2);
            if (bus.if_ack) acks.push_back(1);
        end
        bus.d_req = 0; bus.if_req = 0;
        chk("st_count", 32'(acks.size() >= 6), 32'd1);
        while (acks.size() < 6) acks.push_back(0);
        chk("st_seq", {acks[0][3:0], acks[1][3:0], acks[2][3:0],
                       acks[3][3:0], acks[4][3:0], acks[5][3:0], 8'h0},
            32'h2222_1200);
        tick();

        // reset in the middle of a data read
        bus.d_req = 1; bus.d_we = 0; bus.d_be = 4'hF;
        tick();
        rst = 1'b0;
        tick();
        chk("rr_ce_n", 32'(bus.sram_ce_n), 32'd1);
        chk("rr_busy", 32'(bus.busy), 32'd0);
        chk("rr_no_ack", 32'(bus.d_ack), 32'd0);
        rst = 1'b1; bus.d_req = 0;
        tick();
        chk("rr_no_ack2", 32'(bus.d_ack), 32'd0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if (!bus.if_req) bus.if_req = ($urandom % 3 == 0);
            else if (m_if_ack) bus.if_req = $urandom % 2;
            if (!bus.d_req) bus.d_req = ($urandom % 3 == 0);
            else if (m_d_ack) bus.d_req = $urandom % 2;
            bus.if_flush = ($urandom % 8 == 0);
            bus.if_addr = $urandom & 32'hFFFF_FFFC;
            bus.d_addr = $urandom & 32'hFFFF_FFFC;
            bus.d_we = $urandom % 2;
            bus.d_be = 4'($urandom);
            bus.d_wdata = $urandom;
            bus.sram_data_i = $urandom;
            rst = ($urandom % 150 != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
